// File: rtl/mmcm_ctrl_pkg.sv
// Shared types and sizing helpers for the MMCM input-select / reset sequencer.
package mmcm_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam logic SEL_IN1 = 1'b1;
  localparam logic SEL_IN2 = 1'b0;

  // Bits needed for a counter spanning 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_activity_mon.sv
// Heartbeat activity monitor: synchronises one toggle input, counts edges per
// window (saturating) and latches an alive flag at each window end.
module clk_activity_mon
  import mmcm_ctrl_pkg::*;
#(
  parameter int MIN_TOGGLES = 16
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_hb,
  input  logic i_win_end,
  output logic o_alive
);

  localparam int              CW    = cnt_w(MIN_TOGGLES + 1);
  localparam logic [CW-1:0]   C_MIN = CW'(MIN_TOGGLES);

  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_alive;
  logic          w_tog;

  assign w_tog = r_sync[1] ^ r_prev;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
      r_alive <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_hb};
      r_prev <= r_sync[1];
      if (i_win_end) begin
        r_alive <= (r_cnt >= C_MIN);
        // an edge landing on the closing cycle belongs to the next window
        r_cnt   <= w_tog ? CW'(1) : '0;
      end else if (w_tog && (r_cnt < C_MIN)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_alive = r_alive;

endmodule

// File: rtl/mmcm_clk_sel_ctrl.sv
// MMCM reference-input selector: picks clk_in1/clk_in2 from preference and
// heartbeat activity, sequences MMCM reset around every select change, qualifies lock.
//
// state     | meaning
// HOLD      | MMCM held in reset; select updated on the 2nd cycle
// WAIT_LOCK | reset released, waiting for LOCKED or timeout
// RUN       | locked; watching for lock loss or a new target input
module mmcm_clk_sel_ctrl
  import mmcm_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MON_WINDOW          = 1024,
  parameter int MIN_TOGGLES         = 16
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_hb_in1,
  input  logic       i_hb_in2,
  input  logic       i_sel_pref,
  input  logic       i_auto_en,
  input  logic       i_mmcm_locked,
  output logic       o_mmcm_resetn,
  output logic       o_mmcm_clk_sel,
  output logic       o_locked,
  output logic [1:0] o_alive,
  output logic       o_switch_pulse,
  output logic       o_lost_lock_pulse,
  output logic [7:0] o_retry_cnt
);

  localparam int                HOLD_W    = cnt_w(RST_HOLD_CYCLES);
  localparam int                TMO_W     = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int                WIN_W     = cnt_w(MON_WINDOW);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(MON_WINDOW - 1);

  state_e            r_state, w_state_nxt;
  logic [WIN_W-1:0]  r_win;
  logic [HOLD_W-1:0] r_hold;
  logic [TMO_W-1:0]  r_tmr;
  logic [1:0]        r_lock_sync, r_pref_sync;
  logic              r_mmcm_resetn, r_clk_sel, r_locked, r_switch, r_lost;
  logic [7:0]        r_retry;

  logic       w_win_end, w_locked, w_pref, w_target, w_pref_alive, w_other_alive;
  logic [1:0] w_alive;
  logic       w_ev_lost, w_ev_switch, w_ev_timeout, w_ev_lock;
  logic       w_resetn_d, w_locked_d, w_sel_d;
  logic [7:0] w_retry_d;

  assign w_win_end = (r_win == WIN_LAST);
  assign w_locked  = r_lock_sync[1];
  assign w_pref    = r_pref_sync[1];

  clk_activity_mon #(.MIN_TOGGLES(MIN_TOGGLES)) u_mon_in1 (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_hb(i_hb_in1),
    .i_win_end(w_win_end), .o_alive(w_alive[0])
  );

  clk_activity_mon #(.MIN_TOGGLES(MIN_TOGGLES)) u_mon_in2 (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_hb(i_hb_in2),
    .i_win_end(w_win_end), .o_alive(w_alive[1])
  );

  always_comb begin
    w_pref_alive  = (w_pref == SEL_IN1) ? w_alive[0] : w_alive[1];
    w_other_alive = (w_pref == SEL_IN1) ? w_alive[1] : w_alive[0];
    if (!i_auto_en || w_pref_alive) w_target = w_pref;
    else if (w_other_alive)         w_target = ~w_pref;
    else                            w_target = r_clk_sel;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= HOLD;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ev_lost    = 1'b0;
    w_ev_switch  = 1'b0;
    w_ev_timeout = 1'b0;
    w_ev_lock    = 1'b0;
    case (r_state)
      HOLD: if (r_hold == HOLD_LAST) w_state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (w_locked) begin
          w_state_nxt = RUN;
          w_ev_lock   = 1'b1;
        end else if (r_tmr == TMO_LAST) begin
          w_state_nxt  = HOLD;
          w_ev_timeout = 1'b1;
          w_ev_lost    = 1'b1;
        end
      end
      RUN: begin
        if (!w_locked) begin
          w_state_nxt = HOLD;
          w_ev_lost   = 1'b1;
        end else if (w_target != r_clk_sel) begin
          w_state_nxt = HOLD;
          w_ev_switch = 1'b1;
        end
      end
      default: w_state_nxt = HOLD;
    endcase
  end

  always_comb begin
    w_resetn_d = (w_state_nxt != HOLD);
    w_locked_d = (w_state_nxt == RUN);
    w_sel_d    = ((r_state == HOLD) && (r_hold == '0)) ? w_target : r_clk_sel;
    w_retry_d  = r_retry;
    if (w_ev_lock)                            w_retry_d = '0;
    else if (w_ev_timeout && (r_retry != '1)) w_retry_d = r_retry + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_win         <= '0;
      r_hold        <= '0;
      r_tmr         <= '0;
      r_lock_sync   <= '0;
      // matches the select reset value so a static preference causes no extra switch
      r_pref_sync   <= {2{SEL_IN1}};
      r_mmcm_resetn <= 1'b0;
      r_clk_sel     <= SEL_IN1;
      r_locked      <= 1'b0;
      r_switch      <= 1'b0;
      r_lost        <= 1'b0;
      r_retry       <= '0;
    end else begin
      r_win         <= w_win_end ? '0 : r_win + WIN_W'(1);
      r_hold        <= ((r_state == HOLD) && (w_state_nxt == HOLD)) ? r_hold + HOLD_W'(1) : '0;
      r_tmr         <= ((r_state == WAIT_LOCK) && (w_state_nxt == WAIT_LOCK)) ? r_tmr + TMO_W'(1) : '0;
      r_lock_sync   <= {r_lock_sync[0], i_mmcm_locked};
      r_pref_sync   <= {r_pref_sync[0], i_sel_pref};
      r_mmcm_resetn <= w_resetn_d;
      r_clk_sel     <= w_sel_d;
      r_locked      <= w_locked_d;
      r_switch      <= w_ev_switch;
      r_lost        <= w_ev_lost;
      r_retry       <= w_retry_d;
    end
  end

  assign o_mmcm_resetn     = r_mmcm_resetn;
  assign o_mmcm_clk_sel    = r_clk_sel;
  assign o_locked          = r_locked;
  assign o_alive           = w_alive;
  assign o_switch_pulse    = r_switch;
  assign o_lost_lock_pulse = r_lost;
  assign o_retry_cnt       = r_retry;

endmodule

// File: tb/tb_mmcm_clk_sel_ctrl.sv
// Scoreboard bench for mmcm_clk_sel_ctrl: expected sequencer events are queued
// with each stimulus step and matched by a negedge monitor as the DUT emits them.
module tb_mmcm_clk_sel_ctrl;

  localparam int HOLD_N   = 64;
  localparam int TMO_N    = 128;
  localparam int WIN_N    = 64;
  localparam int MINT_N   = 8;
  localparam int LOCK_DLY = 100;

  localparam int EV_LOST   = 1;
  localparam int EV_SWITCH = 2;
  localparam int EV_LOCK   = 3;
  localparam int EV_HOLD   = 4;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [31:0] mask;
  } sb_t;

  logic       clk;
  logic       i_resetn, i_hb_in1, i_hb_in2, i_sel_pref, i_auto_en, i_mmcm_locked;
  logic       o_mmcm_resetn, o_mmcm_clk_sel, o_locked, o_switch_pulse, o_lost_lock_pulse;
  logic [1:0] o_alive;
  logic [7:0] o_retry_cnt;

  logic hb1_en, hb2_en, lock_en, drop, lock_mdl;
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mmcm_clk_sel_ctrl #(
    .RST_HOLD_CYCLES(HOLD_N), .LOCK_TIMEOUT_CYCLES(TMO_N),
    .MON_WINDOW(WIN_N), .MIN_TOGGLES(MINT_N)
  ) dut (
    .i_clk(clk), .i_resetn(i_resetn), .i_hb_in1(i_hb_in1), .i_hb_in2(i_hb_in2),
    .i_sel_pref(i_sel_pref), .i_auto_en(i_auto_en), .i_mmcm_locked(i_mmcm_locked),
    .o_mmcm_resetn(o_mmcm_resetn), .o_mmcm_clk_sel(o_mmcm_clk_sel), .o_locked(o_locked),
    .o_alive(o_alive), .o_switch_pulse(o_switch_pulse),
    .o_lost_lock_pulse(o_lost_lock_pulse), .o_retry_cnt(o_retry_cnt)
  );

  assign i_mmcm_locked = lock_mdl & ~drop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    i_hb_in1 = 1'b0;
    forever begin
      #23;
      if (hb1_en) i_hb_in1 = ~i_hb_in1;
    end
  end

  initial begin
    i_hb_in2 = 1'b0;
    forever begin
      #31;
      if (hb2_en) i_hb_in2 = ~i_hb_in2;
    end
  end

  // MMCM model: LOCKED rises LOCK_DLY cycles after reset release, drops in reset.
  initial begin
    int cnt;
    cnt      = 0;
    lock_mdl = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!o_mmcm_resetn || !lock_en) begin
        cnt      = 0;
        lock_mdl = 1'b0;
      end else begin
        if (cnt < LOCK_DLY) cnt++;
        lock_mdl = (cnt >= LOCK_DLY);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data, input logic [31:0] mask);
    sb_t e;
    e.kind = kind;
    e.data = data;
    e.mask = mask;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [31:0] data);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected_event", 32'(kind), 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      case (e.kind)
        EV_LOST:   chk("ev_lost",   data & e.mask, e.data & e.mask);
        EV_SWITCH: chk("ev_switch", data & e.mask, e.data & e.mask);
        EV_LOCK:   chk("ev_lock",   data & e.mask, e.data & e.mask);
        default:   chk("ev_hold",   data & e.mask, e.data & e.mask);
      endcase
    end
  endtask

  function automatic logic [31:0] ex_hold(input logic s1, input logic s2);
    return {16'(HOLD_N), 14'd0, s1, s2};
  endfunction

  function automatic logic [31:0] ex_lock(input logic sel);
    return {16'd3, 8'd0, 7'd0, sel};
  endfunction

  function automatic logic [31:0] ex_switch(input logic old_sel);
    return {21'd0, 8'd0, 1'b0, 1'b0, old_sel};
  endfunction

  function automatic logic [31:0] ex_tmo(input int k);
    return {16'(TMO_N), 8'((k > 255) ? 255 : k), 7'd0, 1'b0};
  endfunction

  // Turns DUT output activity into events; low_cnt/high_cnt measure reset phases.
  initial begin
    int   cyc, lockin_cyc, low_cnt, high_cnt;
    logic p_locked, p_mres, p_lockin, sel_first, sel_second;
    cyc = 0; lockin_cyc = 0; low_cnt = 0; high_cnt = 0;
    p_locked = 0; p_mres = 0; p_lockin = 0; sel_first = 1; sel_second = 1;
    forever begin
      @(negedge clk);
      cyc++;
      if (i_mmcm_locked && !p_lockin) lockin_cyc = cyc;
      p_lockin = i_mmcm_locked;
      if (!i_resetn) begin
        low_cnt = 0; high_cnt = 0; p_locked = 0; p_mres = 0;
        continue;
      end
      if (o_lost_lock_pulse)
        sb_check(EV_LOST, {high_cnt[15:0], o_retry_cnt, 7'd0, o_locked});
      if (o_switch_pulse)
        sb_check(EV_SWITCH, {21'd0, o_retry_cnt, o_locked, o_mmcm_resetn, o_mmcm_clk_sel});
      if (o_locked && !p_locked)
        sb_check(EV_LOCK, {16'(cyc - lockin_cyc), o_retry_cnt, 7'd0, o_mmcm_clk_sel});
      if (o_mmcm_resetn && !p_mres)
        sb_check(EV_HOLD, {low_cnt[15:0], 14'd0, sel_first, sel_second});
      if (o_mmcm_resetn) begin
        high_cnt++;
        low_cnt = 0;
      end else begin
        if (low_cnt == 0)      sel_first  = o_mmcm_clk_sel;
        else if (low_cnt == 1) sel_second = o_mmcm_clk_sel;
        low_cnt++;
        high_cnt = 0;
      end
      p_locked = o_locked;
      p_mres   = o_mmcm_resetn;
    end
  end

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    #2;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mmcm_resetn"}, 32'(o_mmcm_resetn), 32'd0);
    chk({tag, "_clk_sel"},     32'(o_mmcm_clk_sel), 32'd1);
    chk({tag, "_locked"},      32'(o_locked), 32'd0);
    chk({tag, "_alive"},       32'(o_alive), 32'd0);
    chk({tag, "_switch"},      32'(o_switch_pulse), 32'd0);
    chk({tag, "_lost"},        32'(o_lost_lock_pulse), 32'd0);
    chk({tag, "_retry"},       32'(o_retry_cnt), 32'd0);
  endtask

  initial begin
    i_resetn = 1'b0; i_sel_pref = 1'b1; i_auto_en = 1'b0;
    hb1_en = 1'b1; hb2_en = 1'b1; lock_en = 1'b1; drop = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_reset("rst");

    push(EV_HOLD, ex_hold(1'b1, 1'b1), '1);
    push(EV_LOCK, ex_lock(1'b1), '1);
    i_resetn = 1'b1;
    drain(400, "bringup");

    push(EV_SWITCH, ex_switch(1'b1), '1);
    push(EV_HOLD, ex_hold(1'b1, 1'b0), '1);
    push(EV_LOCK, ex_lock(1'b0), '1);
    i_sel_pref = 1'b0;
    drain(400, "manual_switch");

    push(EV_SWITCH, ex_switch(1'b0), '1);
    push(EV_HOLD, ex_hold(1'b0, 1'b1), '1);
    push(EV_LOCK, ex_lock(1'b1), '1);
    i_auto_en = 1'b1; i_sel_pref = 1'b1;
    drain(400, "auto_pref_in1");
    chk("alive_both", 32'(o_alive), 32'd3);

    push(EV_SWITCH, ex_switch(1'b1), '1);
    push(EV_HOLD, ex_hold(1'b1, 1'b0), '1);
    push(EV_LOCK, ex_lock(1'b0), '1);
    hb1_en = 1'b0;
    drain(700, "failover_in2");
    chk("alive_in2_only", 32'(o_alive), 32'd2);

    push(EV_SWITCH, ex_switch(1'b0), '1);
    push(EV_HOLD, ex_hold(1'b0, 1'b1), '1);
    push(EV_LOCK, ex_lock(1'b1), '1);
    hb1_en = 1'b1;
    drain(700, "recover_in1");
    chk("alive_recovered", 32'(o_alive), 32'd3);

    // lock loss and preference change seen on the same cycle: lost-lock only
    push(EV_LOST, 32'd0, 32'h0000_FFFF);
    push(EV_HOLD, ex_hold(1'b1, 1'b0), '1);
    push(EV_LOCK, ex_lock(1'b0), '1);
    drop = 1'b1; i_sel_pref = 1'b0;
    @(posedge clk);
    #2;
    drop = 1'b0;
    drain(400, "drop_and_pref");

    push(EV_LOST, 32'd0, 32'h0000_FFFF);
    for (int k = 1; k <= 256; k++) begin
      push(EV_HOLD, ex_hold(1'b0, 1'b0), '1);
      push(EV_LOST, ex_tmo(k), '1);
    end
    push(EV_HOLD, ex_hold(1'b0, 1'b0), '1);
    lock_en = 1'b0;
    drain(52000, "timeouts");

    repeat (10) @(posedge clk);
    #2;
    chk("retry_saturated", 32'(o_retry_cnt), 32'd255);
    chk("wait_lock_resetn", 32'(o_mmcm_resetn), 32'd1);
    lock_en = 1'b1; i_auto_en = 1'b0; i_sel_pref = 1'b1;
    #1;
    i_resetn = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (3) @(posedge clk);
    #2;
    push(EV_HOLD, ex_hold(1'b1, 1'b1), '1);
    push(EV_LOCK, ex_lock(1'b1), '1);
    i_resetn = 1'b1;
    drain(400, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
